// File: rtl/ddr3_ise_readback.sv
// rtl/ddr3_ise_readback.sv - MIG port-0 read-back checker for the incrementing write pattern.
// Optional READBACK_FIRST_ERR_EN adds first_err_addr/first_err_data capture of the first mismatch.
module ddr3_ise_readback #(
  parameter int          BURST_LEN = 4,
  parameter logic [29:0] ADDR_STEP = 30'd64,
  parameter logic [29:0] ADDR_WRAP = 30'h4000,
  parameter int          TIMEOUT   = 1023
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        prepareFin,
  input  logic        go,
  input  logic        c3_p0_cmd_full,
  output logic        c3_p0_cmd_en,
  output logic [2:0]  c3_p0_cmd_instr,
  output logic [5:0]  c3_p0_cmd_bl,
  output logic [29:0] c3_p0_cmd_byte_addr,
  output logic        c3_p0_rd_en,
  input  logic [63:0] c3_p0_rd_data,
  input  logic        c3_p0_rd_empty,
  output logic        busy,
  output logic        error,
  output logic        timeout,
  output logic [15:0] err_cnt,
`ifdef READBACK_FIRST_ERR_EN
  output logic [29:0] first_err_addr,
  output logic [63:0] first_err_data,
`endif
  output logic [15:0] pass_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic [63:0]   expected;
  logic [6:0]    word_cnt;
  logic          burst_bad;
  logic [29:0]   addr_sum;
  logic [29:0]   next_addr;
  logic          mismatch;
  logic          last_word;
`ifdef READBACK_FIRST_ERR_EN
  logic          first_seen;
`endif

  assign c3_p0_cmd_instr = 3'b001;
  assign c3_p0_cmd_bl    = 6'(BURST_LEN - 1);
  assign c3_p0_rd_en     = (state == S_READ) && !c3_p0_rd_empty;
  assign busy            = (state != S_IDLE);
  assign addr_sum        = c3_p0_cmd_byte_addr + ADDR_STEP;
  assign next_addr       = (addr_sum >= ADDR_WRAP) ? 30'd0 : addr_sum;
  assign mismatch        = c3_p0_rd_en && (c3_p0_rd_data != expected);
  assign last_word       = (word_cnt == 7'(BURST_LEN - 1));

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state               <= S_IDLE;
      timer               <= '0;
      expected            <= 64'd1;
      word_cnt            <= '0;
      burst_bad           <= 1'b0;
      c3_p0_cmd_en        <= 1'b0;
      c3_p0_cmd_byte_addr <= '0;
      error               <= 1'b0;
      timeout             <= 1'b0;
      err_cnt             <= '0;
      pass_cnt            <= '0;
`ifdef READBACK_FIRST_ERR_EN
      first_seen          <= 1'b0;
      first_err_addr      <= '0;
      first_err_data      <= '0;
`endif
    end else begin
      c3_p0_cmd_en <= 1'b0;
      // A popped word is always scored, even in the cycle calibration drops.
      if (c3_p0_rd_en) begin
        expected <= expected + 64'd1;
        word_cnt <= word_cnt + 7'd1;
        if (mismatch) begin
          error     <= 1'b1;
          burst_bad <= 1'b1;
          if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
`ifdef READBACK_FIRST_ERR_EN
          if (!first_seen) begin
            first_seen     <= 1'b1;
            first_err_addr <= c3_p0_cmd_byte_addr;
            first_err_data <= c3_p0_rd_data;
          end
`endif
        end
      end
      if (!prepareFin) begin
        state     <= S_IDLE;
        timer     <= '0;
        word_cnt  <= '0;
        burst_bad <= 1'b0;
      end else begin
        case (state)
          S_IDLE:  if (go) state <= S_ISSUE;
          S_ISSUE: if (!c3_p0_cmd_full) begin
            c3_p0_cmd_en <= 1'b1;
            timer        <= '0;
            state        <= S_WAIT;
          end
          S_WAIT: begin
            if (!c3_p0_rd_empty) begin
              timer <= '0;
              state <= S_READ;
            end else if (timer == TW'(TIMEOUT - 1)) begin
              // Skip the lost burst so the next one lines up with the write pattern.
              timer               <= '0;
              timeout             <= 1'b1;
              error               <= 1'b1;
              c3_p0_cmd_byte_addr <= next_addr;
              expected            <= expected + 64'(BURST_LEN);
              state               <= S_IDLE;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          S_READ:  if (c3_p0_rd_en && last_word) state <= S_DONE;
          S_DONE: begin
            if (!burst_bad && pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
            c3_p0_cmd_byte_addr <= next_addr;
            word_cnt            <= '0;
            burst_bad           <= 1'b0;
            state               <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
